uvmt_cvmcu_pad_mux: RTL and testbench

Testbench pad multiplexer that sits directly downstream of the CORE-V MCU DUT pad outputs (io_out_o/io_oe_o). It produces the DUT pad inputs (io_in_i) from a run-time-programmable per-pad routing table. It replaces the hard-wired UART loopback (pad 7 <- pad 8, pad 10 <- pad 9). It supports:
- loopback with programmable delay
- external TB drive
- tie-off
- sticky drive-contention detection

---
 rtl/uvmt_cvmcu_pad_mux.sv | 165 ++++++++++++++++
 tb/tb_uvmt_cvmcu_pad_mux.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uvmt_cvmcu_pad_mux.sv
// Testbench pad mux: builds DUT pad inputs from a per-pad table (TIE / LOOP with delay / EXT drive).
// io_in_o registered (1 cycle, LOOP adds dly); cfg_ready_o drops for the one COMMIT cycle after each accepted write.
module uvmt_cvmcu_pad_mux #(
   parameter int N_IO    = 48,
   parameter int DLY_MAX = 15,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_IO-1:0]   io_out_i,
   input  logic [N_IO-1:0]   io_oe_i,
   output logic [N_IO-1:0]   io_in_o,
   input  logic [N_IO-1:0]   tb_drive_i,
   input  logic              cfg_valid_i,
   output logic              cfg_ready_o,
   input  logic [5:0]        cfg_pad_i,
   input  logic [1:0]        cfg_mode_i,
   input  logic [5:0]        cfg_src_i,
   input  logic [3:0]        cfg_dly_i,
   input  logic              cfg_tie_i,
   output logic              cfg_err_o,
   output logic [N_IO-1:0]   contention_o,
   output logic [CNT_W-1:0]  contention_cnt_o,
   input  logic              contention_clr_i
);

   localparam int DW  = $clog2(DLY_MAX + 1);
   localparam int PCW = $clog2(N_IO + 1);

   localparam logic [1:0] MODE_TIE  = 2'd0;
   localparam logic [1:0] MODE_LOOP = 2'd1;
   localparam logic [1:0] MODE_EXT  = 2'd2;
   localparam logic [1:0] MODE_RSV  = 2'd3;

   // Pads 7 and 10 come up as the UART loopback (7 <- 8, 10 <- 9) pulled high.
   localparam logic [N_IO-1:0] RST_TIE = (N_IO'(1) << 7) | (N_IO'(1) << 10);

   typedef enum logic {ST_IDLE = 1'b0, ST_COMMIT = 1'b1} state_t;

   state_t             state_q, state_d;

   logic [1:0]         mode_q [N_IO];
   logic [5:0]         src_q  [N_IO];
   logic [DW-1:0]      dly_q  [N_IO];
   logic [N_IO-1:0]    tie_q;

   logic [DLY_MAX-1:0] dl_q   [N_IO];
   logic [DLY_MAX-1:0] dl_d   [N_IO];

   logic [N_IO-1:0]    io_in_q, io_in_d;
   logic [N_IO-1:0]    cont_q, cont_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;

   logic               cfg_bad;
   logic               wr_acc;
   logic [N_IO-1:0]    wr_sel;
   logic [N_IO-1:0]    samp;
   logic [N_IO-1:0]    hit;
   logic [PCW-1:0]     pc;
   logic [CNT_W:0]     cnt_sum;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (wr_acc) state_d = ST_COMMIT;
         ST_COMMIT: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cfg_ready_o = (state_q == ST_IDLE);
   end

   always_comb begin
      cfg_bad = ({1'b0, cfg_pad_i} >= 7'(N_IO))
             || (cfg_mode_i == MODE_RSV)
             || ((cfg_mode_i == MODE_LOOP)
                 && (({1'b0, cfg_src_i} >= 7'(N_IO)) || ({1'b0, cfg_dly_i} > 5'(DLY_MAX))));
      wr_acc  = cfg_valid_i && cfg_ready_o && !cfg_bad;
      err_d   = cfg_valid_i && cfg_ready_o && cfg_bad;
      wr_sel  = wr_acc ? (N_IO'(1) << cfg_pad_i) : '0;
   end

   // Tap 0 is the live sample; tap k>0 is the sample from k cycles ago.
   always_comb begin
      samp    = '0;
      hit     = '0;
      io_in_d = '0;
      for (int p = 0; p < N_IO; p++) begin
         samp[p] = io_oe_i[src_q[p]] ? io_out_i[src_q[p]] : tie_q[p];
         hit[p]  = (mode_q[p] == MODE_EXT) && io_oe_i[p];
         dl_d[p] = {dl_q[p][DLY_MAX-2:0], samp[p]};
         case (mode_q[p])
            MODE_EXT:  io_in_d[p] = tb_drive_i[p];
            MODE_LOOP: io_in_d[p] = (dly_q[p] == '0) ? samp[p] : dl_q[p][dly_q[p] - DW'(1)];
            default:   io_in_d[p] = tie_q[p];
         endcase
         if (wr_sel[p]) begin
            io_in_d[p] = cfg_tie_i;
            dl_d[p]    = {DLY_MAX{cfg_tie_i}};
         end
      end
   end

   always_comb begin
      pc = '0;
      for (int p = 0; p < N_IO; p++) begin
         pc = pc + PCW'(hit[p]);
      end
      cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(pc);
      if (contention_clr_i) begin
         cont_d = '0;
         cnt_d  = '0;
      end else begin
         cont_d = cont_q | hit;
         cnt_d  = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < N_IO; p++) begin
            mode_q[p] <= ((p == 7) || (p == 10)) ? MODE_LOOP : MODE_TIE;
            src_q[p]  <= (p == 7) ? 6'd8 : ((p == 10) ? 6'd9 : 6'd0);
            dly_q[p]  <= '0;
            dl_q[p]   <= {DLY_MAX{RST_TIE[p]}};
         end
         tie_q   <= RST_TIE;
         io_in_q <= RST_TIE;
         cont_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         for (int p = 0; p < N_IO; p++) begin
            dl_q[p] <= dl_d[p];
         end
         // Non-LOOP entries park src/dly at 0 so the sample mux never sees an out-of-range source.
         if (wr_acc) begin
            mode_q[cfg_pad_i] <= cfg_mode_i;
            src_q[cfg_pad_i]  <= (cfg_mode_i == MODE_LOOP) ? cfg_src_i : 6'd0;
            dly_q[cfg_pad_i]  <= (cfg_mode_i == MODE_LOOP) ? DW'(cfg_dly_i) : '0;
            tie_q[cfg_pad_i]  <= cfg_tie_i;
         end
         io_in_q <= io_in_d;
         cont_q  <= cont_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign io_in_o          = io_in_q;
   assign cfg_err_o        = err_q;
   assign contention_o     = cont_q;
   assign contention_cnt_o = cnt_q;

endmodule

// File: tb/tb_uvmt_cvmcu_pad_mux.sv
// Bench for uvmt_cvmcu_pad_mux: directed vector table, hand sequences and random traffic,
// all checked each cycle against a cycle-indexed history model of the routing rules.
module tb_uvmt_cvmcu_pad_mux;

   localparam int N   = 48;
   localparam int SAT = 65535;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [N-1:0]  io_out = '0, io_oe = '0, tb_drive = '0;
   logic [N-1:0]  io_in, cont;
   logic          cfg_valid = 1'b0, cfg_tie = 1'b0, clr = 1'b0;
   logic          cfg_ready, cfg_err;
   logic [5:0]    cfg_pad = '0, cfg_src = '0;
   logic [1:0]    cfg_mode = '0;
   logic [3:0]    cfg_dly = '0;
   logic [15:0]   cnt;

   uvmt_cvmcu_pad_mux dut (
      .clk              (clk),
      .reset            (reset),
      .io_out_i         (io_out),
      .io_oe_i          (io_oe),
      .io_in_o          (io_in),
      .tb_drive_i       (tb_drive),
      .cfg_valid_i      (cfg_valid),
      .cfg_ready_o      (cfg_ready),
      .cfg_pad_i        (cfg_pad),
      .cfg_mode_i       (cfg_mode),
      .cfg_src_i        (cfg_src),
      .cfg_dly_i        (cfg_dly),
      .cfg_tie_i        (cfg_tie),
      .cfg_err_o        (cfg_err),
      .contention_o     (cont),
      .contention_cnt_o (cnt),
      .contention_clr_i (clr)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: the table plus, per pad, the first cycle whose sample is valid for its current config.
   int           m_mode [N];
   int           m_src  [N];
   int           m_dly  [N];
   int           m_vf   [N];
   bit           m_tie  [N];
   logic [N-1:0] hist   [32];
   logic [N-1:0] m_in, m_cont;
   int           m_cnt;
   bit           m_commit, m_err;
   int           cyc = 0;

   typedef struct {
      int pad;
      int mode;
      int src;
      int dly;
      bit tie;
      bit exp_err;
   } wr_vec_t;

   wr_vec_t vecs [7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 50) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int p = 0; p < N; p++) begin
         m_mode[p] = ((p == 7) || (p == 10)) ? 1 : 0;
         m_src[p]  = (p == 7) ? 8 : ((p == 10) ? 9 : 0);
         m_dly[p]  = 0;
         m_tie[p]  = (p == 7) || (p == 10);
         m_vf[p]   = cyc;
         m_in[p]   = m_tie[p];
      end
      m_cont   = '0;
      m_cnt    = 0;
      m_commit = 1'b0;
      m_err    = 1'b0;
   endtask

   task automatic step();
      logic [N-1:0] samp, hitv, nxt;
      bit acc, badw;
      int s;
      samp = '0;
      nxt  = '0;
      hitv = '0;
      for (int p = 0; p < N; p++) begin
         if (m_mode[p] == 1) samp[p] = io_oe[m_src[p]] ? io_out[m_src[p]] : m_tie[p];
      end
      hist[cyc % 32] = samp;
      for (int p = 0; p < N; p++) begin
         if (m_mode[p] == 0) nxt[p] = m_tie[p];
         else if (m_mode[p] == 2) nxt[p] = tb_drive[p];
         else begin
            s = cyc - m_dly[p];
            if (s >= m_vf[p]) nxt[p] = hist[s % 32][p];
            else nxt[p] = m_tie[p];
         end
         hitv[p] = (m_mode[p] == 2) && io_oe[p];
      end
      if (clr) begin
         m_cont = '0;
         m_cnt  = 0;
      end else begin
         m_cont = m_cont | hitv;
         m_cnt  = m_cnt + $countones(hitv);
         if (m_cnt > SAT) m_cnt = SAT;
      end
      acc  = cfg_valid && !m_commit;
      badw = (int'(cfg_pad) >= N) || (cfg_mode == 2'd3)
          || ((cfg_mode == 2'd1) && ((int'(cfg_src) >= N) || (int'(cfg_dly) > 15)));
      m_err    = acc && badw;
      m_commit = acc && !badw;
      if (m_commit) begin
         m_mode[cfg_pad] = int'(cfg_mode);
         m_src[cfg_pad]  = int'(cfg_src);
         m_dly[cfg_pad]  = int'(cfg_dly);
         m_tie[cfg_pad]  = cfg_tie;
         m_vf[cfg_pad]   = cyc + 1;
         nxt[cfg_pad]    = cfg_tie;
      end
      m_in = nxt;
      @(posedge clk);
      #1;
      cyc++;
      chk("io_in", 64'(io_in), 64'(m_in));
      chk("ready", 64'(cfg_ready), 64'(!m_commit));
      chk("err", 64'(cfg_err), 64'(m_err));
      chk("contention", 64'(cont), 64'(m_cont));
      chk("cont_cnt", 64'(cnt), 64'(m_cnt));
   endtask

   task automatic cfg_write(input int pad, input int mode, input int src, input int dly, input bit tie);
      cfg_pad   = 6'(pad);
      cfg_mode  = 2'(mode);
      cfg_src   = 6'(src);
      cfg_dly   = 4'(dly);
      cfg_tie   = tie;
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 4 && !cfg_ready; i++) step();
      chk("idle_reached", 64'(cfg_ready), 64'(1));
   endtask

   initial begin
      vecs[0] = '{50, 1, 0,  0,  1'b0, 1'b1};
      vecs[1] = '{5,  3, 0,  0,  1'b0, 1'b1};
      vecs[2] = '{5,  1, 48, 0,  1'b0, 1'b1};
      vecs[3] = '{63, 0, 0,  0,  1'b0, 1'b1};
      vecs[4] = '{47, 0, 63, 15, 1'b1, 1'b0};
      vecs[5] = '{11, 1, 11, 15, 1'b0, 1'b0};
      vecs[6] = '{48, 2, 0,  0,  1'b0, 1'b1};

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      chk("rst_io_in", 64'(io_in), 64'h480);
      chk("rst_ready", 64'(cfg_ready), 64'(1));
      chk("rst_err", 64'(cfg_err), 64'(0));
      chk("rst_cont", 64'(cont), 64'(0));
      chk("rst_cnt", 64'(cnt), 64'(0));

      // UART loopback from reset
      io_out[8] = 1'b1; io_oe[8] = 1'b1;
      step();
      chk("loop7_hi", 64'(io_in[7]), 64'(1));
      io_out[8] = 1'b0;
      step();
      chk("loop7_lo", 64'(io_in[7]), 64'(0));
      chk("pull10", 64'(io_in[10]), 64'(1));
      io_oe[8] = 1'b0;

      // delayed loopback, pad 3 <- pad 20 after 5 cycles
      cfg_write(3, 1, 20, 5, 1'b0);
      chk("commit_ready", 64'(cfg_ready), 64'(0));
      step();
      chk("post_commit_ready", 64'(cfg_ready), 64'(1));
      io_out[20] = 1'b1; io_oe[20] = 1'b1;
      step();
      chk("dly_pad3_k1", 64'(io_in[3]), 64'(0));
      io_out[20] = 1'b0; io_oe[20] = 1'b0;
      for (int k = 2; k <= 8; k++) begin
         step();
         chk("dly_pad3", 64'(io_in[3]), 64'(k == 6));
      end

      // write legality table
      for (int i = 0; i < 7; i++) begin
         cfg_write(vecs[i].pad, vecs[i].mode, vecs[i].src, vecs[i].dly, vecs[i].tie);
         chk("vec_err", 64'(cfg_err), 64'(vecs[i].exp_err));
         chk("vec_ready", 64'(cfg_ready), 64'(vecs[i].exp_err));
         step();
         chk("vec_err_clr", 64'(cfg_err), 64'(0));
         step();
      end
      chk("tie47", 64'(io_in[47]), 64'(1));
      io_out[8] = 1'b1; io_oe[8] = 1'b1;
      step();
      chk("loop7_kept", 64'(io_in[7]), 64'(1));
      io_out[8] = 1'b0; io_oe[8] = 1'b0;

      // external drive and contention on pad 12
      cfg_write(12, 2, 0, 0, 1'b0);
      step();
      for (int i = 0; i < 6; i++) begin
         tb_drive[12] = 1'(i & 1);
         step();
         chk("ext12", 64'(io_in[12]), 64'(i & 1));
      end
      io_oe[12] = 1'b1;
      repeat (3) step();
      io_oe[12] = 1'b0;
      chk("cont12", 64'(cont[12]), 64'(1));
      chk("cnt3", 64'(cnt), 64'(3));
      step();
      chk("cnt3_hold", 64'(cnt), 64'(3));
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_cont", 64'(cont), 64'(0));
      chk("clr_cnt", 64'(cnt), 64'(0));

      // saturation with two contending pads
      cfg_write(13, 2, 0, 0, 1'b0);
      step();
      io_oe[12] = 1'b1; io_oe[13] = 1'b1;
      repeat (40000) step();
      chk("cnt_sat", 64'(cnt), 64'(SAT));
      chk("cont_12_13", 64'(cont[13:12]), 64'(3));
      io_oe = '0;
      clr = 1'b1;
      step();
      clr = 1'b0;

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         io_out    = N'({$urandom(), $urandom()});
         io_oe     = N'({$urandom(), $urandom()});
         tb_drive  = N'({$urandom(), $urandom()});
         clr       = ($urandom_range(0, 63) == 0);
         cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_pad   = 6'($urandom_range(0, 55));
         cfg_mode  = 2'($urandom_range(0, 3));
         cfg_src   = 6'($urandom_range(0, 52));
         cfg_dly   = 4'($urandom_range(0, 15));
         cfg_tie   = 1'($urandom_range(0, 1));
         step();
      end
      cfg_valid = 1'b0; clr = 1'b0;
      io_out = '0; io_oe = '0; tb_drive = '0;
      wait_idle();

      // reset while a pad 3 write is committing
      cfg_write(3, 1, 20, 3, 1'b1);
      chk("commit2_ready", 64'(cfg_ready), 64'(0));
      chk("commit2_tie", 64'(io_in[3]), 64'(1));
      reset = 1'b1;
      #1;
      chk("arst_io_in", 64'(io_in), 64'h480);
      chk("arst_ready", 64'(cfg_ready), 64'(1));
      chk("arst_err", 64'(cfg_err), 64'(0));
      chk("arst_cont", 64'(cont), 64'(0));
      chk("arst_cnt", 64'(cnt), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      io_out[20] = 1'b1; io_oe[20] = 1'b1;
      repeat (6) step();
      chk("pad3_tie0", 64'(io_in), 64'h480);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
